// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and defaults for the dmem_responder slice
package dmem_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam int DEPTH_DEFAULT = 64;
    localparam int WAIT_DEFAULT  = 2;
    localparam int CNT_W         = 4;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word RAM, synchronous write, registered read
module dmem_array #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_rclr,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Storage is never reset; only the read register has a clear.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_rclr) begin
            r_rdata <= 32'd0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-stated data memory responder; optional DMEM_MISALIGN_CHECK_EN
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int WAIT  = WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        ready,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [AW-1:0]     r_idx;
    logic [31:0]       r_wdata;
    logic              r_wr;
    logic              r_mis;
    logic              r_ready;
    logic              r_err;

    logic              w_req;
    logic              w_idle;
    logic              w_mis_in;
    logic              w_done_next;
    logic [AW-1:0]     w_idx;
    logic [31:0]       w_wdata;
    logic              w_wr;
    logic              w_mis;
    logic              w_we;
    logic              w_re;
    logic              w_rclr;

`ifdef DMEM_MISALIGN_CHECK_EN
    assign w_mis_in = (dataadr[1:0] != 2'b00);
    logic w_unused_adr;
    assign w_unused_adr = ^dataadr[31:AW+2];
`else
    assign w_mis_in = 1'b0;
    logic w_unused_adr;
    assign w_unused_adr = ^{dataadr[31:AW+2], dataadr[1:0]};
`endif

    assign w_req  = memread | memwrite;
    assign w_idle = (r_state == S_IDLE);

    // With zero wait states the access happens on the request edge itself,
    // so the RAM must see the live inputs rather than the latched copy.
    assign w_done_next = (w_idle && w_req && (WAIT == 0)) ||
                         ((r_state == S_WAIT) && (r_cnt == CNT_W'(1)));

    assign w_idx   = w_idle ? dataadr[AW+1:2] : r_idx;
    assign w_wdata = w_idle ? writedata       : r_wdata;
    assign w_wr    = w_idle ? memwrite        : r_wr;
    assign w_mis   = w_idle ? w_mis_in        : r_mis;

    assign w_we   = ~reset & w_done_next & w_wr & ~w_mis;
    assign w_re   = ~reset & w_done_next & ~w_wr & ~w_mis;
    assign w_rclr = reset | (w_done_next & w_mis);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= w_done_next;
            r_err   <= w_done_next & w_mis;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_idx   <= dataadr[AW+1:2];
                        r_wdata <= writedata;
                        r_wr    <= memwrite;
                        r_mis   <= w_mis_in;
                        if (WAIT == 0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= CNT_W'(WAIT);
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .i_rclr  (w_rclr),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (w_idx),
        .i_wdata (w_wdata),
        .o_rdata (readdata)
    );

    assign ready = r_ready;
    assign err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized bench with a word-array reference model
module tb_dmem_responder;

    localparam int DEPTH = 16;
    localparam int WAITC = 2;
    localparam int AW    = $clog2(DEPTH);

`ifdef DMEM_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, memwrite, memread;
    logic [31:0] dataadr, writedata, readdata;
    logic        ready, err;

    logic        b_reset, b_memwrite, b_memread;
    logic [31:0] b_dataadr, b_writedata, b_readdata;
    logic        b_ready, b_err;

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] mdl_mem [DEPTH];
    logic [31:0] mdl_rd;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .WAIT(WAITC)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .memread(memread),
        .dataadr(dataadr), .writedata(writedata),
        .readdata(readdata), .ready(ready), .err(err)
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT(0)) dut0 (
        .clk(clk), .reset(b_reset), .memwrite(b_memwrite), .memread(b_memread),
        .dataadr(b_dataadr), .writedata(b_writedata),
        .readdata(b_readdata), .ready(b_ready), .err(b_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic access(input string tag, input bit wr, input bit rd,
                          input logic [31:0] adr, input logic [31:0] data);
        int  lat;
        bit  mis;
        int  idx;
        @(negedge clk);
        memwrite = wr; memread = rd; dataadr = adr; writedata = data;
        lat = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end while (!ready && lat < 20);
        memwrite = 1'b0; memread = 1'b0;
        check({tag, "_latency"}, lat, WAITC + 1);
        mis = MIS_EN && (adr[1:0] != 2'b00);
        idx = int'(adr[AW+1:2]);
        if (mis) mdl_rd = 32'd0;
        else if (wr) mdl_mem[idx] = data;
        else mdl_rd = mdl_mem[idx];
        check({tag, "_err"}, {31'd0, err}, {31'd0, mis});
        check({tag, "_rdata"}, readdata, mdl_rd);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_ready_drop"}, {31'd0, ready}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; memwrite = 1'b0; memread = 1'b0; dataadr = '0; writedata = '0;
        b_reset = 1'b1; b_memwrite = 1'b0; b_memread = 1'b0; b_dataadr = '0; b_writedata = '0;
        mdl_rd = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; b_reset = 1'b0;
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdata", readdata, 32'd0);

        for (int i = 0; i < DEPTH; i++) access("init", 1'b1, 1'b0, 32'(i * 4), $urandom);

        access("st4", 1'b1, 1'b0, 32'd4, 32'hF00D_0000);
        access("ld4", 1'b0, 1'b1, 32'd4, 32'h0);
        access("ld4_alias", 1'b0, 1'b1, 32'd4 + 32'(4 * DEPTH), 32'h0);
        access("both8", 1'b1, 1'b1, 32'd8, 32'h1234_5678);
        access("ld8", 1'b0, 1'b1, 32'd8, 32'h0);

        // Reset while the store to 12 is waiting: no completion, no write.
        @(negedge clk);
        memwrite = 1'b1; dataadr = 32'd12; writedata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; memwrite = 1'b0;
        mdl_rd = 32'd0;
        check("rst_wait_rdata", readdata, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("rst_wait_noready", {31'd0, ready}, 32'd0);
            @(negedge clk);
        end
        access("ld12", 1'b0, 1'b1, 32'd12, 32'h0);

        access("st6", 1'b1, 1'b0, 32'd6, 32'hCAFE_0006);
        access("ld4_after6", 1'b0, 1'b1, 32'd4, 32'h0);

        for (int i = 0; i < 40; i++) begin
            bit wr, rd;
            wr = $urandom_range(0, 1) == 1;
            rd = !wr || ($urandom_range(0, 3) == 0);
            access("rnd", wr, rd, $urandom, $urandom);
        end

        // Zero-wait instance: a held store completes every other cycle.
        @(negedge clk);
        b_memwrite = 1'b1; b_dataadr = 32'd4; b_writedata = 32'h0000_0A5A;
        begin
            bit prev;
            prev = 1'b0;
            for (int k = 1; k <= 6; k++) begin
                @(posedge clk);
                @(negedge clk);
                check("w0_ready", {31'd0, b_ready}, {31'd0, k[0]});
                check("w0_no_back2back", {31'd0, prev & b_ready}, 32'd0);
                prev = b_ready;
            end
        end
        b_memwrite = 1'b0;
        @(negedge clk);
        b_memread = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_memread = 1'b0;
        check("w0_ld_ready", {31'd0, b_ready}, 32'd1);
        check("w0_ld_rdata", b_readdata, 32'h0000_0A5A);
        check("w0_err", {31'd0, b_err}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
